// File: rtl/mem_rw_sched.sv
// mem_rw_sched: weighted read/write arbitration of the single DDR burst engine with per-burst watchdog; MEM_SCHED_STAT_EN adds completion/abort counters.
module mem_rw_sched #(
    parameter int MEM_DATA_BITS = 256,
    parameter int ADDR_WIDTH    = 30,
    parameter int WR_WEIGHT     = 2,
    parameter int TIMEOUT_CYC   = 8000
) (
    input  logic                     ddr_clk_i,
    input  logic                     ddr_rst_i,
    input  logic                     rd_req_i,
    input  logic [7:0]               rd_len_i,
    input  logic [ADDR_WIDTH-1:0]    rd_addr_i,
    output logic                     rd_data_valid_o,
    output logic [MEM_DATA_BITS-1:0] rd_data_o,
    output logic                     rd_finish_o,
    input  logic                     wr_req_i,
    input  logic [7:0]               wr_len_i,
    input  logic [ADDR_WIDTH-1:0]    wr_addr_i,
    output logic                     wr_data_req_o,
    input  logic [MEM_DATA_BITS-1:0] wr_data_i,
    output logic                     wr_finish_o,
    output logic                     mem_rd_req_o,
    output logic [7:0]               mem_rd_len_o,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr_o,
    input  logic                     mem_rd_data_valid_i,
    input  logic [MEM_DATA_BITS-1:0] mem_rd_data_i,
    input  logic                     mem_rd_finish_i,
    output logic                     mem_wr_req_o,
    output logic [7:0]               mem_wr_len_o,
    output logic [ADDR_WIDTH-1:0]    mem_wr_addr_o,
    input  logic                     mem_wr_data_req_i,
    input  logic                     mem_wr_finish_i,
    output logic [MEM_DATA_BITS-1:0] mem_wr_data_o,
`ifdef MEM_SCHED_STAT_EN
    output logic [15:0]              stat_rd_cnt_o,
    output logic [15:0]              stat_wr_cnt_o,
    output logic [15:0]              stat_to_cnt_o,
`endif
    output logic                     timeout_o
);
    typedef enum logic [2:0] {IDLE, ARB, RD_BEGIN, RD_BUSY, RD_END, WR_BEGIN, WR_BUSY, WR_END} state_t;
    localparam logic [3:0]  WW = 4'(WR_WEIGHT);
    localparam logic [15:0] TO = 16'(TIMEOUT_CYC);
    state_t      state, nxt;
    logic [3:0]  wr_cnt;
    logic [15:0] cnt_timer;
    logic [1:0]  rd_fin_q, wr_fin_q;
    logic        rd_vld, wr_vld, active, timeout;
    assign rd_vld  = rd_req_i & (rd_len_i != 8'd0);
    assign wr_vld  = wr_req_i & (wr_len_i != 8'd0);
    assign active  = (state != IDLE) && (state != ARB);
    assign timeout = active && (cnt_timer > TO);
    assign timeout_o       = timeout;
    assign rd_finish_o     = state == RD_END;
    assign wr_finish_o     = state == WR_END;
    assign rd_data_valid_o = mem_rd_data_valid_i & (state == RD_BUSY);
    assign rd_data_o       = (state == RD_BUSY) ? mem_rd_data_i : '0;
    assign wr_data_req_o   = mem_wr_data_req_i & (state == WR_BUSY);
    assign mem_wr_data_o   = wr_data_i;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = ARB;
            ARB:      nxt = (wr_vld && (!rd_vld || wr_cnt < WW)) ? WR_BEGIN : rd_vld ? RD_BEGIN : ARB;
            RD_BEGIN: nxt = RD_BUSY;
            RD_BUSY:  nxt = rd_fin_q[1] ? RD_END : RD_BUSY;
            RD_END:   nxt = ARB;
            WR_BEGIN: nxt = WR_BUSY;
            WR_BUSY:  nxt = wr_fin_q[1] ? WR_END : WR_BUSY;
            WR_END:   nxt = ARB;
            default:  nxt = IDLE;
        endcase
        if (timeout) nxt = IDLE;
    end
    // finish is only accepted inside the matching BUSY state so stray pulses never leak into a later burst
    always_ff @(posedge ddr_clk_i) begin
        if (ddr_rst_i) begin
            state         <= IDLE;
            wr_cnt        <= '0;
            cnt_timer     <= '0;
            rd_fin_q      <= '0;
            wr_fin_q      <= '0;
            mem_rd_req_o  <= 1'b0;
            mem_rd_len_o  <= '0;
            mem_rd_addr_o <= '0;
            mem_wr_req_o  <= 1'b0;
            mem_wr_len_o  <= '0;
            mem_wr_addr_o <= '0;
        end else begin
            state     <= nxt;
            cnt_timer <= active ? cnt_timer + 16'd1 : '0;
            rd_fin_q  <= {rd_fin_q[0], mem_rd_finish_i & (state == RD_BUSY)};
            wr_fin_q  <= {wr_fin_q[0], mem_wr_finish_i & (state == WR_BUSY)};
            if (state == RD_BEGIN) begin
                mem_rd_len_o  <= rd_len_i;
                mem_rd_addr_o <= rd_addr_i;
            end
            if (state == WR_BEGIN) begin
                mem_wr_len_o  <= wr_len_i;
                mem_wr_addr_o <= wr_addr_i;
            end
            mem_rd_req_o <= !timeout && (state == RD_BEGIN || (mem_rd_req_o && !(state == RD_BUSY && mem_rd_data_valid_i)));
            mem_wr_req_o <= !timeout && (state == WR_BEGIN || (mem_wr_req_o && !(state == WR_BUSY && mem_wr_data_req_i)));
            wr_cnt <= (state == RD_BEGIN) ? '0 : (state == WR_BEGIN && wr_cnt < WW) ? wr_cnt + 4'd1 : wr_cnt;
        end
    end
`ifdef MEM_SCHED_STAT_EN
    always_ff @(posedge ddr_clk_i) begin
        if (ddr_rst_i) begin
            stat_rd_cnt_o <= '0;
            stat_wr_cnt_o <= '0;
            stat_to_cnt_o <= '0;
        end else begin
            if (state == RD_END && stat_rd_cnt_o != 16'hFFFF) stat_rd_cnt_o <= stat_rd_cnt_o + 16'd1;
            if (state == WR_END && stat_wr_cnt_o != 16'hFFFF) stat_wr_cnt_o <= stat_wr_cnt_o + 16'd1;
            if (timeout && stat_to_cnt_o != 16'hFFFF) stat_to_cnt_o <= stat_to_cnt_o + 16'd1;
        end
    end
`endif
endmodule
